// File: rtl/gth_serializer_pkg.sv
// Shared types and constants for the three-lane TMDS-style GTH serializer.
package gth_serializer_pkg;

    localparam int SYMBOL_W  = 10;
    localparam int NUM_LANES = 3;
    localparam int PHASE_W   = 16;

    localparam logic [SYMBOL_W-1:0] TMDS_CLK_PATTERN = 10'b0000011111;

    typedef enum logic [2:0] {
        ST_POWERUP  = 3'd0,
        ST_PLL_LOCK = 3'd1,
        ST_PMA_RST  = 3'd2,
        ST_PRGDIV   = 3'd3,
        ST_TX_RST   = 3'd4,
        ST_ACTIVE   = 3'd5
    } gth_state_e;

    function automatic logic [SYMBOL_W-1:0] bit_reverse(input logic [SYMBOL_W-1:0] sym);
        logic [SYMBOL_W-1:0] rev;
        rev = '0;
        for (int i = 0; i < SYMBOL_W; i++) begin
            rev[i] = sym[SYMBOL_W-1-i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/gth_lane_shifter.sv
// One serial lane: 10-bit parallel load, right shift, LSB drives the p/n pair.
module gth_lane_shifter
    import gth_serializer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [SYMBOL_W-1:0] din,
    output logic                p,
    output logic                n
);

    logic [SYMBOL_W-1:0] shift_r;

    // Load a new word on the word boundary, otherwise shift toward the LSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r <= '0;
        end else if (load) begin
            shift_r <= din;
        end else begin
            shift_r <= {1'b0, shift_r[SYMBOL_W-1:1]};
        end
    end

    assign p = shift_r[0];
    assign n = ~shift_r[0];

endmodule

// File: rtl/gth_serializer.sv
// Three-lane TMDS serializer with GT-style bring-up sequencing and clock lane.
// Define GTH_SERIALIZER_MSB_FIRST_EN to transmit data symbols bit 9 first.
module gth_serializer
    import gth_serializer_pkg::*;
#(
    parameter int POWERGOOD_CYCLES = 16,
    parameter int LOCK_CYCLES      = 64,
    parameter int PMA_CYCLES       = 32,
    parameter int PRGDIV_CYCLES    = 16,
    parameter int TXDONE_CYCLES    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SYMBOL_W-1:0] r,
    input  logic [SYMBOL_W-1:0] g,
    input  logic [SYMBOL_W-1:0] b,
    output logic                gthtxp_out_0,
    output logic                gthtxn_out_0,
    output logic                gthtxp_out_1,
    output logic                gthtxn_out_1,
    output logic                gthtxp_out_2,
    output logic                gthtxn_out_2,
    output logic                tmds_clk_p,
    output logic                tmds_clk_n,
    output logic [2:0]          gtpowergood_out,
    output logic                locked,
    output logic [2:0]          txpmaresetdone_out,
    output logic [2:0]          rxpmaresetdone_out,
    output logic [2:0]          txprgdivresetdone_out,
    output logic                gtwiz_reset_tx_done_out,
    output logic                gtwiz_reset_rx_cdr_stable_out,
    output logic                out_en
);

    gth_state_e          state_r;
    logic [PHASE_W-1:0]  phase_cnt_r;
    logic [3:0]          bit_cnt_r;
    logic                load_s;
    logic                phase_done_s;
    logic [SYMBOL_W-1:0] lane_din_s [NUM_LANES];
    logic [SYMBOL_W-1:0] clk_din_s;
    logic [NUM_LANES-1:0] lane_p_s;
    logic [NUM_LANES-1:0] lane_n_s;

    assign load_s = (bit_cnt_r == 4'd9);

    // Free-running word phase counter, wraps 9 -> 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_r <= 4'd0;
        end else if (load_s) begin
            bit_cnt_r <= 4'd0;
        end else begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
        end
    end

    // Terminal count of the phase counter for the current bring-up state.
    always_comb begin
        phase_done_s = 1'b0;
        case (state_r)
            ST_POWERUP:  phase_done_s = (phase_cnt_r == PHASE_W'(POWERGOOD_CYCLES - 1));
            ST_PLL_LOCK: phase_done_s = (phase_cnt_r == PHASE_W'(LOCK_CYCLES - 1));
            ST_PMA_RST:  phase_done_s = (phase_cnt_r == PHASE_W'(PMA_CYCLES - 1));
            ST_PRGDIV:   phase_done_s = (phase_cnt_r == PHASE_W'(PRGDIV_CYCLES - 1));
            ST_TX_RST:   phase_done_s = (phase_cnt_r == PHASE_W'(TXDONE_CYCLES - 1));
            default:     phase_done_s = 1'b0;
        endcase
    end

    // Bring-up sequencer; status flags are sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r                 <= ST_POWERUP;
            phase_cnt_r             <= '0;
            gtpowergood_out         <= 3'b000;
            locked                  <= 1'b0;
            txpmaresetdone_out      <= 3'b000;
            rxpmaresetdone_out      <= 3'b000;
            txprgdivresetdone_out   <= 3'b000;
            gtwiz_reset_tx_done_out <= 1'b0;
            out_en                  <= 1'b0;
        end else begin
            if (load_s && (state_r == ST_ACTIVE)) begin
                out_en <= 1'b1;
            end
            if (state_r == ST_ACTIVE) begin
                phase_cnt_r <= '0;
            end else if (phase_done_s) begin
                phase_cnt_r <= '0;
            end else begin
                phase_cnt_r <= phase_cnt_r + PHASE_W'(1);
            end
            if (phase_done_s) begin
                case (state_r)
                    ST_POWERUP: begin
                        gtpowergood_out <= 3'b111;
                        state_r         <= ST_PLL_LOCK;
                    end
                    ST_PLL_LOCK: begin
                        locked  <= 1'b1;
                        state_r <= ST_PMA_RST;
                    end
                    ST_PMA_RST: begin
                        txpmaresetdone_out <= 3'b111;
                        rxpmaresetdone_out <= 3'b111;
                        state_r            <= ST_PRGDIV;
                    end
                    ST_PRGDIV: begin
                        txprgdivresetdone_out <= 3'b111;
                        state_r               <= ST_TX_RST;
                    end
                    ST_TX_RST: begin
                        gtwiz_reset_tx_done_out <= 1'b1;
                        state_r                 <= ST_ACTIVE;
                    end
                    default: begin
                        state_r <= state_r;
                    end
                endcase
            end
        end
    end

    // Live symbols only once ACTIVE; before that the lanes idle at zero.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_din_s[i] = '0;
        end
        clk_din_s = '0;
        if (state_r == ST_ACTIVE) begin
`ifdef GTH_SERIALIZER_MSB_FIRST_EN
            lane_din_s[0] = bit_reverse(b);
            lane_din_s[1] = bit_reverse(g);
            lane_din_s[2] = bit_reverse(r);
`else
            lane_din_s[0] = b;
            lane_din_s[1] = g;
            lane_din_s[2] = r;
`endif
            clk_din_s = TMDS_CLK_PATTERN;
        end else begin
            clk_din_s = '0;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        gth_lane_shifter u_lane (
            .clk   (clk),
            .reset (reset),
            .load  (load_s),
            .din   (lane_din_s[k]),
            .p     (lane_p_s[k]),
            .n     (lane_n_s[k])
        );
    end

    gth_lane_shifter u_clk_lane (
        .clk   (clk),
        .reset (reset),
        .load  (load_s),
        .din   (clk_din_s),
        .p     (tmds_clk_p),
        .n     (tmds_clk_n)
    );

    assign gthtxp_out_0 = lane_p_s[0];
    assign gthtxn_out_0 = lane_n_s[0];
    assign gthtxp_out_1 = lane_p_s[1];
    assign gthtxn_out_1 = lane_n_s[1];
    assign gthtxp_out_2 = lane_p_s[2];
    assign gthtxn_out_2 = lane_n_s[2];

    assign gtwiz_reset_rx_cdr_stable_out = 1'b0;

endmodule

// File: tb/tb_gth_serializer.sv
// Randomized self-checking bench for gth_serializer against an edge-count reference model.
module tb_gth_serializer;

    localparam int P_PG   = 16;
    localparam int P_LOCK = 64;
    localparam int P_PMA  = 32;
    localparam int P_PRG  = 16;
    localparam int P_TX   = 16;

    localparam int T_PG     = P_PG;
    localparam int T_LOCK   = T_PG + P_LOCK;
    localparam int T_PMA    = T_LOCK + P_PMA;
    localparam int T_PRG    = T_PMA + P_PRG;
    localparam int T_TX     = T_PRG + P_TX;
    localparam int T_LOAD1  = ((T_TX / 10) + 1) * 10;

    logic       clk;
    logic       reset;
    logic [9:0] r, g, b;
    logic       p0, n0, p1, n1, p2, n2, ck_p, ck_n;
    logic [2:0] pg, txpma, rxpma, prgdiv;
    logic       lock, txdone, cdr, out_en;

    int vec_cnt;
    int miscmp_cnt;
    int n_edge;
    logic [9:0] word_r, word_g, word_b;

    gth_serializer #(
        .POWERGOOD_CYCLES (P_PG),
        .LOCK_CYCLES      (P_LOCK),
        .PMA_CYCLES       (P_PMA),
        .PRGDIV_CYCLES    (P_PRG),
        .TXDONE_CYCLES    (P_TX)
    ) dut (
        .clk                           (clk),
        .reset                         (reset),
        .r                             (r),
        .g                             (g),
        .b                             (b),
        .gthtxp_out_0                  (p0),
        .gthtxn_out_0                  (n0),
        .gthtxp_out_1                  (p1),
        .gthtxn_out_1                  (n1),
        .gthtxp_out_2                  (p2),
        .gthtxn_out_2                  (n2),
        .tmds_clk_p                    (ck_p),
        .tmds_clk_n                    (ck_n),
        .gtpowergood_out               (pg),
        .locked                        (lock),
        .txpmaresetdone_out            (txpma),
        .rxpmaresetdone_out            (rxpma),
        .txprgdivresetdone_out         (prgdiv),
        .gtwiz_reset_tx_done_out       (txdone),
        .gtwiz_reset_rx_cdr_stable_out (cdr),
        .out_en                        (out_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n_edge, obs, exp);
        end
    endtask

    // Serial position j of a symbol, in transmit order.
    function automatic logic sym_bit(input logic [9:0] sym, input int j);
`ifdef GTH_SERIALIZER_MSB_FIRST_EN
        return sym[9-j];
`else
        return sym[j];
`endif
    endfunction

    // Advance one edge, update the model, and compare every output.
    task automatic step();
        int   j;
        logic live;
        logic [2:0] exp_data;
        logic exp_ck;
        @(posedge clk);
        if (reset) n_edge = 0;
        else       n_edge++;
        if (n_edge > 0 && (n_edge % 10) == 0) begin
            word_r = r;
            word_g = g;
            word_b = b;
        end
        #1;
        j    = n_edge % 10;
        live = ((n_edge / 10) * 10 >= T_LOAD1);
        exp_data = live ? {sym_bit(word_r, j), sym_bit(word_g, j), sym_bit(word_b, j)} : 3'b000;
        exp_ck   = live ? (j < 5) : 1'b0;
        check_val("data_p", {29'd0, p2, p1, p0}, {29'd0, exp_data});
        check_val("data_n", {29'd0, n2, n1, n0}, {29'd0, ~exp_data});
        check_val("clk_p", {31'd0, ck_p}, {31'd0, exp_ck});
        check_val("clk_n", {31'd0, ck_n}, {31'd0, ~exp_ck});
        check_val("powergood", {29'd0, pg}, (n_edge >= T_PG) ? 32'd7 : 32'd0);
        check_val("locked", {31'd0, lock}, (n_edge >= T_LOCK) ? 32'd1 : 32'd0);
        check_val("pma_done", {26'd0, txpma, rxpma}, (n_edge >= T_PMA) ? 32'h3F : 32'd0);
        check_val("prgdiv", {29'd0, prgdiv}, (n_edge >= T_PRG) ? 32'd7 : 32'd0);
        check_val("tx_done", {31'd0, txdone}, (n_edge >= T_TX) ? 32'd1 : 32'd0);
        check_val("cdr_stable", {31'd0, cdr}, 32'd0);
        check_val("out_en", {31'd0, out_en}, (n_edge >= T_LOAD1) ? 32'd1 : 32'd0);
    endtask

    initial begin
        vec_cnt    = 0;
        miscmp_cnt = 0;
        n_edge     = 0;
        word_r     = 10'h000;
        word_g     = 10'h000;
        word_b     = 10'h000;
        reset      = 1'b1;
        r          = 10'h3FF;
        g          = 10'h1FF;
        b          = 10'h0FF;

        for (int i = 0; i < 100; i++) step();
        reset = 1'b0;

        // Bring-up with fixed symbols, a mid-word change on b, then random words.
        for (int i = 0; i < 260; i++) begin
            step();
            if (n_edge == 165) b = 10'h001;
            if (n_edge >= 200 && ($urandom_range(0, 3) == 0)) begin
                r = 10'($urandom);
                g = 10'($urandom);
                b = 10'($urandom);
            end
        end

        // Reset while ACTIVE, then a full repeat of the bring-up.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        for (int i = 0; i < 230; i++) begin
            step();
            if ($urandom_range(0, 2) == 0) begin
                r = 10'($urandom);
                g = 10'($urandom);
                b = 10'($urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
